// File: rtl/axil_timeout_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_timeout_if
// Brief    : AXI4-Lite channel bundle with master/slave modports.
// Revision : 1.0
// ============================================================================
interface axil_timeout_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/axil_timeout.sv
`default_nettype none
// ============================================================================
// Module   : axil_timeout
// Brief    : AXI4-Lite timeout guard; answers SLVERR when the downstream side
//            stalls and drains the late transaction. Optional timeout pulses
//            enabled by AXIL_TIMEOUT_STATUS_EN.
// Revision : 1.0
// ============================================================================
module axil_timeout #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 1024
) (
    input  wire            clk,
    input  wire            rst,
    axil_timeout_if.slave  s_axil,
    axil_timeout_if.master m_axil
`ifdef AXIL_TIMEOUT_STATUS_EN
    ,
    output logic           timeout_wr,
    output logic           timeout_rd
`endif
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_REQ   = 3'd1;
    localparam logic [2:0] c_ST_RESP  = 3'd2;
    localparam logic [2:0] c_ST_ACK   = 3'd3;
    localparam logic [2:0] c_ST_FLUSH = 3'd4;

    // ------------------------------------------------------------------ write
    logic [2:0]            r_wr_state;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [2:0]            r_awprot;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_b_done;
    logic [1:0]            r_bresp;
    logic [CNT_W-1:0]      r_wr_cnt;

    logic w_wr_accept, w_m_awvalid, w_m_wvalid, w_m_bready;
    logic w_aw_hs, w_w_hs, w_b_hs;
    logic w_aw_done, w_w_done, w_b_done, w_wr_timing, w_wr_expire;

    // Ready is gated with rst so nothing is accepted while reset is held.
    assign w_wr_accept = (r_wr_state == c_ST_IDLE) && !rst && s_axil.awvalid && s_axil.wvalid;
    assign w_m_awvalid = (r_wr_state != c_ST_IDLE) && !r_aw_done;
    assign w_m_wvalid  = (r_wr_state != c_ST_IDLE) && !r_w_done;
    assign w_m_bready  = ((r_wr_state == c_ST_RESP) || (r_wr_state == c_ST_ACK) ||
                          (r_wr_state == c_ST_FLUSH)) && !r_b_done;

    assign w_aw_hs   = w_m_awvalid && m_axil.awready;
    assign w_w_hs    = w_m_wvalid && m_axil.wready;
    assign w_b_hs    = w_m_bready && m_axil.bvalid;
    assign w_aw_done = r_aw_done || w_aw_hs;
    assign w_w_done  = r_w_done || w_w_hs;
    assign w_b_done  = r_b_done || w_b_hs;

    assign w_wr_timing = (r_wr_state == c_ST_REQ) || (r_wr_state == c_ST_RESP);
    // A real response in the final cycle takes priority over the timeout.
    assign w_wr_expire = w_wr_timing && (r_wr_cnt == c_CNT_LAST) && !w_b_hs;

    assign s_axil.awready = w_wr_accept;
    assign s_axil.wready  = w_wr_accept;
    assign s_axil.bvalid  = (r_wr_state == c_ST_ACK);
    assign s_axil.bresp   = r_bresp;
    assign m_axil.awaddr  = r_awaddr;
    assign m_axil.awprot  = r_awprot;
    assign m_axil.awvalid = w_m_awvalid;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = r_wstrb;
    assign m_axil.wvalid  = w_m_wvalid;
    assign m_axil.bready  = w_m_bready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= c_ST_IDLE;
            r_awaddr   <= '0;
            r_awprot   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_b_done   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_cnt   <= '0;
        end else begin
            if (r_wr_state != c_ST_IDLE) begin
                r_aw_done <= w_aw_done;
                r_w_done  <= w_w_done;
                r_b_done  <= w_b_done;
            end
            if (w_wr_timing && (r_wr_cnt != c_CNT_LAST)) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            case (r_wr_state)
                c_ST_IDLE: begin
                    if (w_wr_accept) begin
                        r_awaddr   <= s_axil.awaddr;
                        r_awprot   <= s_axil.awprot;
                        r_wdata    <= s_axil.wdata;
                        r_wstrb    <= s_axil.wstrb;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_b_done   <= 1'b0;
                        r_wr_cnt   <= '0;
                        r_wr_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (w_wr_expire) begin
                        r_bresp    <= 2'b10;
                        r_wr_state <= c_ST_ACK;
                    end else if (w_aw_done && w_w_done) begin
                        r_wr_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    if (w_b_hs) begin
                        r_bresp    <= m_axil.bresp;
                        r_wr_state <= c_ST_ACK;
                    end else if (w_wr_expire) begin
                        r_bresp    <= 2'b10;
                        r_wr_state <= c_ST_ACK;
                    end
                end
                c_ST_ACK: begin
                    if (s_axil.bready) begin
                        r_wr_state <= (w_aw_done && w_w_done && w_b_done) ? c_ST_IDLE : c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    if (w_aw_done && w_w_done && w_b_done) begin
                        r_wr_state <= c_ST_IDLE;
                    end
                end
                default: r_wr_state <= c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------- read
    logic [2:0]            r_rd_state;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [2:0]            r_arprot;
    logic                  r_ar_done;
    logic                  r_r_done;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CNT_W-1:0]      r_rd_cnt;

    logic w_rd_accept, w_m_arvalid, w_m_rready, w_ar_hs, w_r_hs;
    logic w_ar_done, w_r_done, w_rd_timing, w_rd_expire;

    assign w_rd_accept = (r_rd_state == c_ST_IDLE) && !rst && s_axil.arvalid;
    assign w_m_arvalid = (r_rd_state != c_ST_IDLE) && !r_ar_done;
    assign w_m_rready  = ((r_rd_state == c_ST_RESP) || (r_rd_state == c_ST_ACK) ||
                          (r_rd_state == c_ST_FLUSH)) && !r_r_done;

    assign w_ar_hs   = w_m_arvalid && m_axil.arready;
    assign w_r_hs    = w_m_rready && m_axil.rvalid;
    assign w_ar_done = r_ar_done || w_ar_hs;
    assign w_r_done  = r_r_done || w_r_hs;

    assign w_rd_timing = (r_rd_state == c_ST_REQ) || (r_rd_state == c_ST_RESP);
    assign w_rd_expire = w_rd_timing && (r_rd_cnt == c_CNT_LAST) && !w_r_hs;

    assign s_axil.arready = w_rd_accept;
    assign s_axil.rvalid  = (r_rd_state == c_ST_ACK);
    assign s_axil.rresp   = r_rresp;
    assign s_axil.rdata   = r_rdata;
    assign m_axil.araddr  = r_araddr;
    assign m_axil.arprot  = r_arprot;
    assign m_axil.arvalid = w_m_arvalid;
    assign m_axil.rready  = w_m_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= c_ST_IDLE;
            r_araddr   <= '0;
            r_arprot   <= '0;
            r_ar_done  <= 1'b0;
            r_r_done   <= 1'b0;
            r_rresp    <= 2'b00;
            r_rdata    <= '0;
            r_rd_cnt   <= '0;
        end else begin
            if (r_rd_state != c_ST_IDLE) begin
                r_ar_done <= w_ar_done;
                r_r_done  <= w_r_done;
            end
            if (w_rd_timing && (r_rd_cnt != c_CNT_LAST)) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            case (r_rd_state)
                c_ST_IDLE: begin
                    if (w_rd_accept) begin
                        r_araddr   <= s_axil.araddr;
                        r_arprot   <= s_axil.arprot;
                        r_ar_done  <= 1'b0;
                        r_r_done   <= 1'b0;
                        r_rd_cnt   <= '0;
                        r_rd_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (w_rd_expire) begin
                        r_rresp    <= 2'b10;
                        r_rdata    <= '0;
                        r_rd_state <= c_ST_ACK;
                    end else if (w_ar_done) begin
                        r_rd_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    if (w_r_hs) begin
                        r_rresp    <= m_axil.rresp;
                        r_rdata    <= m_axil.rdata;
                        r_rd_state <= c_ST_ACK;
                    end else if (w_rd_expire) begin
                        r_rresp    <= 2'b10;
                        r_rdata    <= '0;
                        r_rd_state <= c_ST_ACK;
                    end
                end
                c_ST_ACK: begin
                    if (s_axil.rready) begin
                        r_rd_state <= (w_ar_done && w_r_done) ? c_ST_IDLE : c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    if (w_ar_done && w_r_done) begin
                        r_rd_state <= c_ST_IDLE;
                    end
                end
                default: r_rd_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef AXIL_TIMEOUT_STATUS_EN
    // Pulses line up with the first ACK cycle of a timed-out transaction.
    logic r_wr_to;
    logic r_rd_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_to <= 1'b0;
            r_rd_to <= 1'b0;
        end else begin
            r_wr_to <= w_wr_expire;
            r_rd_to <= w_rd_expire;
        end
    end

    assign timeout_wr = r_wr_to;
    assign timeout_rd = r_rd_to;
`endif
endmodule
`default_nettype wire

// File: doc/axil_timeout.md
AXIL_TIMEOUT -- requirements
Module: axil_timeout

Interface
REQ-001 ADDR_WIDTH, 32, address bus width in bits.
REQ-002 DATA_WIDTH, 32, data bus width in bits.
REQ-003 STRB_WIDTH, DATA_WIDTH/8, wstrb width.
REQ-004 TIMEOUT, 1024, max cycles a transaction may wait on the master side; legal range >= 2.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 s_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1; s_axil_awready  out  1; AXI-lite slave AW.
REQ-008 s_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1; s_axil_wready  out  1; slave W.
REQ-009 s_axil_bresp/bvalid  out  2/1; s_axil_bready  in  1; slave B.
REQ-010 s_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1; s_axil_arready  out  1; slave AR.
REQ-011 s_axil_rdata/rresp/rvalid  out  DATA_WIDTH/2/1; s_axil_rready  in  1; slave R.
REQ-012 m_axil_aw*/w*/b*/ar*/r*: mirror of REQ-007..011 with directions reversed; master side toward the downstream target (e.g. one output port of the man-in-the-middle fan-out).
REQ-013 timeout_wr, timeout_rd  out  1 each; single-cycle timeout pulses (present only with AXIL_TIMEOUT_STATUS_EN).

Function
REQ-014 Write and read paths: independent FSMs, states IDLE, REQ, RESP, ACK, FLUSH; one outstanding transaction per path.
REQ-015 Write IDLE: s_axil_awready = s_axil_wready = (s_axil_awvalid & s_axil_wvalid); on accept, register addr/prot/data/strb, go REQ.
REQ-016 REQ: m_axil_awvalid and m_axil_wvalid each held from registers until its own handshake; both done -> RESP.
REQ-017 RESP: m_axil_bready=1; on m_axil_bvalid capture bresp, go ACK.
REQ-018 ACK: s_axil_bvalid=1 with captured bresp; on s_axil_bready -> FLUSH if master side incomplete, else IDLE.
REQ-019 Timer: cleared on entering REQ, increments each cycle in REQ/RESP, saturating; at count==TIMEOUT-1 without completion that cycle -> ACK with bresp=2'b10 (SLVERR).
REQ-020 Simultaneous real response and timeout: real response wins, no error.
REQ-021 After timeout, pending m valids stay asserted until accepted (never dropped); late B accepted (m_axil_bready=1) and discarded, in ACK or FLUSH.
REQ-022 FLUSH: new slave requests blocked (ready=0); -> IDLE once AW, W, B all complete on master side.
REQ-023 Read path identical: arready = arvalid in IDLE; m_axil_rready=1 in RESP/ACK/FLUSH; timeout gives rresp=2'b10, rdata=0.
REQ-024 Latency with no timeout: s accept -> m valid 1 cycle; m response -> s valid 1 cycle.

Reset
REQ-025 rst asserted: immediately all valid/ready outputs 0, FSMs IDLE, timers 0, registered payloads and resp 0, pulses 0.
REQ-026 Reset mid-transaction abandons it silently; the downstream target shall be reset by the same rst.

Configuration
REQ-027 AXIL_TIMEOUT_STATUS_EN defined: timeout_wr/timeout_rd exist, pulse 1 cycle on the cycle a path enters ACK via timeout; undefined: ports absent, behaviour otherwise identical.

Verification
REQ-028 Write 0x10=0xDEADBEEF, target answers B OKAY after 3 cycles -> s_axil_bresp=00, no pulse, m AW/W seen 1 cycle after accept.
REQ-029 TIMEOUT=8, target never asserts arready -> s_axil_rvalid with rresp=10, rdata=0 after 8 cycles in REQ, timeout_rd pulse, m_axil_arvalid held.
REQ-030 TIMEOUT=8, AW/W accepted, B arrives 20 cycles later -> SLVERR to master, late B swallowed, next write blocked until B, then accepted normally.
REQ-031 B arrives exactly on count==TIMEOUT-1 -> real bresp forwarded, no pulse.
REQ-032 Concurrent read and write, plus rst asserted mid-RESP -> paths independent; after reset all outputs 0, next transaction completes OKAY.
